// File: rtl/fifo_wr_arbiter_if.sv
// Three-requester write port plus downstream FIFO write side and grant status.
// Master is the requester/FIFO environment; slave is the arbiter.
interface fifo_wr_arbiter_if #(
    parameter int WIDTH = 5
);
    logic             valid0;
    logic             valid1;
    logic             valid2;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic [WIDTH-1:0] data2;
    logic             ready0;
    logic             ready1;
    logic             ready2;
    logic [WIDTH-1:0] fifo_wdata;
    logic             fifo_wen;
    logic             fifo_full;
    logic [1:0]       grant;
    logic             busy;

    modport master (
        output valid0, valid1, valid2, data0, data1, data2, fifo_full,
        input  ready0, ready1, ready2, fifo_wdata, fifo_wen, grant, busy
    );

    modport slave (
        input  valid0, valid1, valid2, data0, data1, data2, fifo_full,
        output ready0, ready1, ready2, fifo_wdata, fifo_wen, grant, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter: three requesters share one FIFO write port, up to BURST words per grant.
// One IDLE cycle of arbitration per grant; writes are combinational in GRANT and stall while fifo_full.
module fifo_wr_arbiter #(
    parameter int WIDTH = 5,
    parameter int BURST = 4
) (
    input logic              CLK,
    input logic              RESET,
    fifo_wr_arbiter_if.slave bus
);
    localparam int CW = $clog2(BURST + 1);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic [1:0]     owner, owner_nxt;
    logic [1:0]     last, last_nxt;
    logic [CW-1:0]  beats, beats_nxt;

    logic [2:0]       valid_vec;
    logic [1:0]       cand1, cand2, pick;
    logic             own_valid;
    logic [WIDTH-1:0] own_data;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    assign valid_vec = {bus.valid2, bus.valid1, bus.valid0};

    // Search last+1, last+2, then last itself, so a waiting peer always wins over a repeat.
    always_comb begin
        cand1 = next_idx(last);
        cand2 = next_idx(cand1);
        if (valid_vec[cand1])      pick = cand1;
        else if (valid_vec[cand2]) pick = cand2;
        else                       pick = last;
    end

    always_comb begin
        own_valid = 1'b0;
        own_data  = '0;
        case (owner)
            2'd0: begin own_valid = bus.valid0; own_data = bus.data0; end
            2'd1: begin own_valid = bus.valid1; own_data = bus.data1; end
            default: begin own_valid = bus.valid2; own_data = bus.data2; end
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
            owner <= 2'd0;
            last  <= 2'd2;
            beats <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            last  <= last_nxt;
            beats <= beats_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        owner_nxt      = owner;
        last_nxt       = last;
        beats_nxt      = beats;
        bus.ready0     = 1'b0;
        bus.ready1     = 1'b0;
        bus.ready2     = 1'b0;
        bus.fifo_wen   = 1'b0;
        bus.fifo_wdata = '0;
        bus.busy       = 1'b0;
        bus.grant      = 2'd0;

        case (state)
            IDLE: begin
                if (|valid_vec) begin
                    state_nxt = GRANT;
                    owner_nxt = pick;
                    beats_nxt = '0;
                end
            end
            GRANT: begin
                bus.busy       = 1'b1;
                bus.grant      = owner;
                bus.ready0     = (owner == 2'd0) && !bus.fifo_full;
                bus.ready1     = (owner == 2'd1) && !bus.fifo_full;
                bus.ready2     = (owner == 2'd2) && !bus.fifo_full;
                bus.fifo_wen   = own_valid && !bus.fifo_full;
                bus.fifo_wdata = own_data;

                if (!own_valid) begin
                    state_nxt = IDLE;
                    last_nxt  = owner;
                    beats_nxt = '0;
                end else if (!bus.fifo_full) begin
                    // This transfer is the one that brings the count to BURST.
                    if (beats == CW'(BURST - 1)) begin
                        state_nxt = IDLE;
                        last_nxt  = owner;
                        beats_nxt = '0;
                    end else begin
                        beats_nxt = beats + CW'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench: cycle model of the arbitration rules plus literal per-scenario expectations.
module tb_fifo_wr_arbiter;
    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    fifo_wr_arbiter_if #(.WIDTH(5)) bus ();
    fifo_wr_arbiter_if #(.WIDTH(5)) b1 ();

    fifo_wr_arbiter #(.WIDTH(5), .BURST(4)) dut (.CLK(CLK), .RESET(RESET), .bus(bus.slave));
    fifo_wr_arbiter #(.WIDTH(5), .BURST(1)) dut1 (.CLK(CLK), .RESET(RESET), .bus(b1.slave));

    assign b1.valid0    = 1'b1;
    assign b1.valid1    = 1'b1;
    assign b1.valid2    = 1'b1;
    assign b1.data0     = 5'd1;
    assign b1.data1     = 5'd2;
    assign b1.data2     = 5'd3;
    assign b1.fifo_full = 1'b0;

    int checks = 0;
    int failures = 0;

    int base[3] = '{3, 8, 16};
    int seq[3];
    int quota[3];
    logic [2:0] acc = '0;

    int cyc = 0;
    int grant_log[$];
    int rise_log[$];
    int wr_log[$];
    int busy_cnt, stall_cnt;
    bit prev_busy = 0;
    bit b1_done = 0;

    // Model state: whether a grant is active, its owner, words still allowed, last owner served.
    int m_busy = 0, m_owner = 0, m_left = 0, m_last = 2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic cmp_q(input string name, input int act[$], input int exp[$]);
        check({name, "_len"}, act.size(), exp.size());
        for (int i = 0; i < exp.size() && i < act.size(); i++)
            check(name, act[i], exp[i]);
    endtask

    task automatic update_inputs();
        bus.valid0 = seq[0] < quota[0];
        bus.valid1 = seq[1] < quota[1];
        bus.valid2 = seq[2] < quota[2];
        bus.data0  = 5'(base[0] + seq[0]);
        bus.data1  = 5'(base[1] + seq[1]);
        bus.data2  = 5'(base[2] + seq[2]);
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        for (int i = 0; i < 3; i++) if (acc[i]) seq[i]++;
        update_inputs();
    endtask

    task automatic new_test();
        grant_log.delete();
        rise_log.delete();
        wr_log.delete();
        busy_cnt = 0;
        stall_cnt = 0;
        for (int i = 0; i < 3; i++) begin seq[i] = 0; quota[i] = 0; end
        update_inputs();
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int budget);
        int k = 0;
        while (wr_log.size() < n && k < budget) begin tick(); k++; end
        check("wait_writes_timeout", 32'(wr_log.size() >= n), 32'd1);
    endtask

    // Per-cycle compare against the model, then advance the model by one clock.
    always @(negedge CLK) begin
        logic [2:0] vin, e_ready;
        logic [4:0] din[3];
        logic e_wen;
        logic [4:0] e_wdata;
        bit found;
        int c;
        cyc++;
        vin = {bus.valid2, bus.valid1, bus.valid0};
        din[0] = bus.data0; din[1] = bus.data1; din[2] = bus.data2;
        if (RESET) begin
            check("rst_busy", bus.busy, 0);
            check("rst_grant", bus.grant, 0);
            check("rst_wen", bus.fifo_wen, 0);
            check("rst_ready", {bus.ready2, bus.ready1, bus.ready0}, 0);
            check("rst_wdata", bus.fifo_wdata, 0);
            m_busy = 0; m_owner = 0; m_left = 0; m_last = 2;
            acc = '0;
            prev_busy = 0;
        end else begin
            e_ready = '0; e_wen = 1'b0; e_wdata = '0;
            if (m_busy != 0) begin
                e_ready[m_owner] = !bus.fifo_full;
                e_wen = vin[m_owner] && !bus.fifo_full;
                e_wdata = din[m_owner];
            end
            check("busy", bus.busy, m_busy);
            if (m_busy != 0) check("grant", bus.grant, m_owner);
            check("ready", {bus.ready2, bus.ready1, bus.ready0}, e_ready);
            check("wen", bus.fifo_wen, e_wen);
            check("wdata", bus.fifo_wdata, e_wdata);

            if (bus.busy && !prev_busy) begin
                grant_log.push_back(int'(bus.grant));
                rise_log.push_back(cyc);
            end
            if (bus.busy) busy_cnt++;
            if (bus.busy && bus.fifo_full) stall_cnt++;
            if (bus.fifo_wen) wr_log.push_back(int'(bus.fifo_wdata));
            acc = vin & {bus.ready2, bus.ready1, bus.ready0};
            prev_busy = bus.busy;

            if (m_busy == 0) begin
                found = 0;
                for (int k = 1; k <= 3; k++) begin
                    c = (m_last + k) % 3;
                    if (!found && vin[c]) begin
                        found = 1; m_busy = 1; m_owner = c; m_left = 4;
                    end
                end
            end else if (!vin[m_owner]) begin
                m_busy = 0; m_last = m_owner;
            end else if (!bus.fifo_full) begin
                m_left--;
                if (m_left == 0) begin m_busy = 0; m_last = m_owner; end
            end
        end
    end

    // BURST=1 instance: all requesters always valid, so grants alternate with idle cycles 0,1,2,0.
    initial begin
        logic [4:0] gexp[4];
        int gi;
        gexp[0] = 5'd0; gexp[1] = 5'd1; gexp[2] = 5'd2; gexp[3] = 5'd0;
        gi = 0;
        @(negedge RESET);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK);
            check("b1_busy", b1.busy, 32'(i % 2));
            check("b1_wen", b1.fifo_wen, 32'(i % 2));
            if (i % 2 == 1) begin
                check("b1_grant", b1.grant, gexp[gi]);
                check("b1_wdata", b1.fifo_wdata, gexp[gi] + 5'd1);
                gi++;
            end
        end
        b1_done = 1;
    end

    initial begin
        int e[$];
        int set_cyc;
        bus.fifo_full = 1'b0;
        new_test();
        tick();
        tick();
        RESET = 1'b0;

        // Single requester: four words, one-cycle arbitration latency.
        quota[0] = 4;
        update_inputs();
        set_cyc = cyc;
        repeat (10) tick();
        e = '{0}; cmp_q("t1_grants", grant_log, e);
        e = '{3, 4, 5, 6}; cmp_q("t1_words", wr_log, e);
        if (rise_log.size() > 0) check("t1_latency", rise_log[0], set_cyc + 2);
        check("t1_busy_cycles", busy_cnt, 4);

        // All three requesting: rotation 0,1,2,0 with one idle cycle between bursts.
        new_test();
        do_reset();
        quota[0] = 8; quota[1] = 4; quota[2] = 4;
        update_inputs();
        repeat (30) tick();
        e = '{0, 1, 2, 0}; cmp_q("t2_grants", grant_log, e);
        e = '{3, 4, 5, 6, 8, 9, 10, 11, 16, 17, 18, 19, 7, 8, 9, 10};
        cmp_q("t2_words", wr_log, e);
        for (int i = 1; i < rise_log.size(); i++)
            check("t2_gap", rise_log[i] - rise_log[i-1], 5);

        // FIFO full for three cycles mid-burst stalls without losing beats.
        new_test();
        do_reset();
        quota[1] = 4;
        update_inputs();
        wait_writes(2, 20);
        bus.fifo_full = 1'b1;
        repeat (3) tick();
        bus.fifo_full = 1'b0;
        repeat (12) tick();
        e = '{1}; cmp_q("t3_grants", grant_log, e);
        e = '{8, 9, 10, 11}; cmp_q("t3_words", wr_log, e);
        check("t3_busy_cycles", busy_cnt, 7);
        check("t3_stall_cycles", stall_cnt, 3);

        // Owner 2 drops valid after one word; last becomes 2 so requester 0 is next.
        new_test();
        quota[2] = 1;
        update_inputs();
        wait_writes(1, 20);
        quota[0] = 1; quota[1] = 1;
        update_inputs();
        repeat (15) tick();
        e = '{2, 0, 1}; cmp_q("t4_grants", grant_log, e);
        e = '{16, 3, 8}; cmp_q("t4_words", wr_log, e);
        if (rise_log.size() > 1) check("t4_regrant_gap", rise_log[1] - rise_log[0], 3);

        // Reset during the third beat aborts it; requester 0 wins afterwards.
        new_test();
        quota[1] = 4;
        update_inputs();
        wait_writes(2, 20);
        RESET = 1'b1;
        @(negedge CLK);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_wen", bus.fifo_wen, 0);
        tick();
        RESET = 1'b0;
        quota[0] = 2;
        update_inputs();
        repeat (20) tick();
        e = '{1, 0, 1}; cmp_q("t5_grants", grant_log, e);
        e = '{8, 9, 3, 4, 10, 11}; cmp_q("t5_words", wr_log, e);

        check("b1_done", b1_done, 1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter WIDTH, default 5, SHALL be the data width of every data port.
REQ-002 Parameter BURST, default 4, SHALL be the maximum number of transfers per grant (legal range 1..15).
REQ-003 CLK  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 RESET  input  1  SHALL be an asynchronous, active-high reset.
REQ-005 valid0/valid1/valid2  input  1 each  SHALL indicate that requester N offers a word.
REQ-006 data0/data1/data2  input  WIDTH each  SHALL carry requester N's word.
REQ-007 ready0/ready1/ready2  output  1 each  SHALL indicate that requester N's word is accepted this cycle when its valid is high.
REQ-008 fifo_wdata  output  WIDTH  SHALL drive the downstream FIFO write data.
REQ-009 fifo_wen  output  1  SHALL drive the downstream FIFO write enable.
REQ-010 fifo_full  input  1  SHALL be the downstream FIFO full flag.
REQ-011 grant  output  2  SHALL be the index of the current owner (0..2), meaningful only while busy=1.
REQ-012 busy  output  1  SHALL be high while the FSM is in GRANT.

Function
REQ-013 The FSM SHALL have two states, IDLE and GRANT, plus a registered owner index, a last-served index and a beat counter of width ceil(log2(BURST+1)).
REQ-014 In IDLE with any validN high, the FSM SHALL select the first requester with valid high, searching in the order last+1, last+2, last+3 (mod 3), and enter GRANT next cycle with that owner and the counter at 0.
REQ-015 In IDLE with no valid high, the FSM SHALL stay in IDLE.
REQ-016 In IDLE, all readyN and fifo_wen SHALL be 0; arbitration latency SHALL be exactly one cycle from valid to first possible transfer.
REQ-017 In GRANT, ready[owner] SHALL equal ~fifo_full combinationally; every other readyN SHALL be 0.
REQ-018 In GRANT, fifo_wen SHALL equal valid[owner] & ~fifo_full, and fifo_wdata SHALL equal data[owner] combinationally.
REQ-019 In IDLE, fifo_wdata SHALL be all zeros.
REQ-020 A transfer SHALL be any GRANT cycle with fifo_wen=1; each transfer SHALL increment the counter by 1.
REQ-021 The FSM SHALL leave GRANT for IDLE after the transfer that brings the counter to BURST.
REQ-022 The FSM SHALL leave GRANT for IDLE in any GRANT cycle where valid[owner]=0.
REQ-023 While fifo_full=1 and valid[owner]=1, the FSM SHALL hold GRANT with no transfer and no counter change.
REQ-024 On every exit from GRANT, last SHALL be loaded with owner and the counter cleared.
REQ-025 There SHALL be one IDLE bubble cycle between consecutive grants.
REQ-026 A requester SHALL never be granted twice in a row while another requester held valid high during the intervening IDLE cycle.
REQ-027 The design SHALL NOT drop, duplicate or reorder words within one requester's stream.

Reset
REQ-028 RESET=1 SHALL immediately force state IDLE, owner 0, counter 0 and last 2, so requester 0 has first priority.
REQ-029 During and after reset, busy, grant, fifo_wen, all readyN and fifo_wdata SHALL be 0.
REQ-030 Reset asserted mid-burst SHALL abort the burst with no transfer in the reset cycle; the aborted word remains the requester's responsibility.

Verification
REQ-031 Reset, then valid0=1 with data0=5'h03..06 and fifo_full=0 -> busy rises 1 cycle later; 4 transfers 03,04,05,06 with grant=0; then 1 IDLE cycle.
REQ-032 valid0, valid1 and valid2 held high with fifo_full=0 -> grants in order 0,1,2,0, each 4 transfers, with one-cycle gaps.
REQ-033 Owner 1 granted; fifo_full=1 for 3 cycles after 2 transfers -> ready1=0 and fifo_wen=0 for 3 cycles; burst resumes and ends after 2 more transfers.
REQ-034 Owner 2 drops valid2 after 1 transfer -> FSM returns to IDLE next cycle; last=2; the next grant goes to 0 if valid0=1.
REQ-035 RESET pulsed during the 3rd beat of a burst -> busy=0 and fifo_wen=0 in that cycle; after release, requester 0 wins again.
REQ-036 Parameter BURST=1 with all valids high -> exactly one transfer per grant, rotating 0,1,2.
